// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default widths for the SRAM port arbiter and the memory-stage blocks.
package sram_port_arbiter_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_MEM
    } owner_t;

endpackage

// File: rtl/sram_access_timer.sv
// Access-cycle counter: loads 1 on grant, counts while the access runs,
// flags the last strobe cycle and whether the upcoming cycle is inside the write window.
module sram_access_timer
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last_c,
    output logic we_win_nxt_c
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = CNT_W'(1);
        end else if (en) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign last_c       = (cnt == LAST_CNT);
    // Strobes are registered, so the write window is judged on the count they will accompany.
    assign we_win_nxt_c = (cnt_nxt >= CNT_W'(2));

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the off-chip SRAM port between instruction fetch and data memory,
// running each access as a fixed-length cycle with registered strobes.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = SRAM_ADDR_W,
    parameter int unsigned DATA_W        = SRAM_DATA_W,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    state_t            state, state_d;
    owner_t            owner, owner_d;
    owner_t            last_owner, last_owner_d;
    logic              acc_we, acc_we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] if_rdata_d, mem_rdata_d;
    logic              if_ack_d, mem_ack_d;
    logic              grant_if, grant_mem;
    logic              timer_en;
    logic              last_c, we_win_nxt_c;
    logic              ce_n_d, oe_n_d, we_n_d, dq_oe_d;

    sram_access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (grant_if | grant_mem),
        .en          (timer_en),
        .last_c      (last_c),
        .we_win_nxt_c(we_win_nxt_c)
    );

    // Arbitration, sequencing and completion.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        acc_we_d     = acc_we;
        addr_d       = sram_addr;
        dout_d       = sram_dout;
        if_rdata_d   = if_rdata;
        mem_rdata_d  = mem_rdata;
        if_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;
        grant_if     = 1'b0;
        grant_mem    = 1'b0;
        timer_en     = 1'b0;

        case (state)
            IDLE: begin
                if (if_req && mem_req) begin
                    if (last_owner == OWN_IF) grant_mem = 1'b1;
                    else                      grant_if  = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end else if (mem_req) begin
                    grant_mem = 1'b1;
                end
            end
            ACCESS: begin
                timer_en = ~last_c;
                if (last_c) begin
                    state_d = RELEASE;
                    if (owner == OWN_IF) begin
                        if_ack_d = 1'b1;
                        if (!acc_we) if_rdata_d = sram_din;
                    end else if (owner == OWN_MEM) begin
                        mem_ack_d = 1'b1;
                        if (!acc_we) mem_rdata_d = sram_din;
                    end
                end
            end
            RELEASE: begin
                // Only the requester not just served may chain straight into a new access.
                if (owner == OWN_IF && mem_req) begin
                    grant_mem = 1'b1;
                end else if (owner == OWN_MEM && if_req) begin
                    grant_if = 1'b1;
                end else begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        if (grant_if) begin
            state_d      = ACCESS;
            owner_d      = OWN_IF;
            last_owner_d = OWN_IF;
            acc_we_d     = 1'b0;
            addr_d       = if_addr;
        end else if (grant_mem) begin
            state_d      = ACCESS;
            owner_d      = OWN_MEM;
            last_owner_d = OWN_MEM;
            acc_we_d     = mem_we;
            addr_d       = mem_addr;
            dout_d       = mem_wdata;
        end
    end

    // Strobe values for the cycle that follows the coming edge.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (state_d == ACCESS) begin
            ce_n_d  = 1'b0;
            oe_n_d  = acc_we_d;
            dq_oe_d = acc_we_d;
            we_n_d  = ~(acc_we_d & we_win_nxt_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            last_owner <= OWN_IF;
            acc_we     <= 1'b0;
            sram_addr  <= '0;
            sram_dout  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if_ack     <= 1'b0;
            mem_ack    <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_owner_d;
            acc_we     <= acc_we_d;
            sram_addr  <= addr_d;
            sram_dout  <= dout_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_dq_oe <= dq_oe_d;
            if_ack     <= if_ack_d;
            mem_ack    <= mem_ack_d;
            if_rdata   <= if_rdata_d;
            mem_rdata  <= mem_rdata_d;
        end
    end

    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized checks of the SRAM port arbiter against a word-level memory model.
module tb_sram_port_arbiter;

    localparam int unsigned AW    = 18;
    localparam int unsigned DW    = 16;
    localparam int          BOUND = 2 * 2 + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          if_req, if_ack, if_stall, mem_req, mem_we, mem_ack, mem_stall;
    logic [AW-1:0] if_addr, mem_addr, sram_addr;
    logic [DW-1:0] if_rdata, mem_wdata, mem_rdata, sram_dout, sram_din;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic          if_req5, if_ack5, if_stall5, mem_ack5, mem_stall5;
    logic [AW-1:0] if_addr5, sram_addr5;
    logic [DW-1:0] if_rdata5, mem_rdata5, sram_dout5, sram_din5;
    logic          sram_dq_oe5, sram_ce_n5, sram_oe_n5, sram_we_n5;

    int n_checks = 0;
    int n_pass   = 0;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dq_oe(sram_dq_oe), .sram_din(sram_din),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(5)) dut5 (
        .clk(clk), .rst(rst),
        .if_req(if_req5), .if_addr(if_addr5), .if_ack(if_ack5), .if_rdata(if_rdata5), .if_stall(if_stall5),
        .mem_req(1'b0), .mem_we(1'b0), .mem_addr('0), .mem_wdata('0),
        .mem_ack(mem_ack5), .mem_rdata(mem_rdata5), .mem_stall(mem_stall5),
        .sram_addr(sram_addr5), .sram_dout(sram_dout5), .sram_dq_oe(sram_dq_oe5), .sram_din(sram_din5),
        .sram_ce_n(sram_ce_n5), .sram_oe_n(sram_oe_n5), .sram_we_n(sram_we_n5)
    );

    // Behavioural 64-word SRAM (address aliased on the low 6 bits).
    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 35) ? 16'hBEEF : 16'(i * 16'h0931 + 16'h1C07);
    endfunction

    logic          init_mem;
    logic [DW-1:0] smem    [64];
    logic [DW-1:0] ref_mem [64];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) smem[i] <= init_word(i);
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            smem[sram_addr[5:0]] <= sram_dout;
        end
    end

    always_comb sram_din  = (!sram_ce_n && !sram_oe_n) ? smem[sram_addr[5:0]] : 16'h0000;
    always_comb sram_din5 = (!sram_ce_n5 && !sram_oe_n5) ? 16'hC0DE : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_we_n", sram_we_n, 1);
        repeat (2) step();
        rst = 1'b0;
    endtask

    int acks;
    int if_wait, mem_wait;
    logic [AW-1:0] if_a, mem_a;
    logic          mem_w;
    logic [DW-1:0] mem_d;

    initial begin
        rst = 1'b0; init_mem = 1'b1;
        if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
        if_req5 = 0; if_addr5 = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        #1 rst = 1'b1;
        #1;
        // Reset values before any clock edge.
        check("rst_ce", sram_ce_n, 1);
        check("rst_oe", sram_oe_n, 1);
        check("rst_we", sram_we_n, 1);
        check("rst_dqoe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dout", sram_dout, 0);
        check("rst_acks", {if_ack, mem_ack}, 0);
        check("rst_rdata", {if_rdata, mem_rdata}, 0);
        repeat (2) step();
        init_mem = 1'b0; rst = 1'b0;
        step();

        // Single IF read.
        if_addr = 18'h00123; if_req = 1'b1;
        step();
        check("t1_c1_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b001);
        check("t1_addr", sram_addr, 18'h00123);
        check("t1_c1_ack", if_ack, 0);
        check("t1_c1_stall", if_stall, 1);
        step();
        check("t1_c2_strobes", {sram_ce_n, sram_oe_n}, 2'b00);
        check("t1_c2_ack", if_ack, 0);
        step();
        check("t1_rel_strobes", {sram_ce_n, sram_oe_n}, 2'b11);
        check("t1_ack", if_ack, 1);
        check("t1_rdata", if_rdata, 16'hBEEF);
        check("t1_stall", if_stall, 0);
        if_req = 1'b0;
        step();
        check("t1_ack_pulse", if_ack, 0);
        check("t1_idle_ce", sram_ce_n, 1);

        // MEM write.
        mem_we = 1'b1; mem_addr = 18'h3FFFF; mem_wdata = 16'h5A5A; mem_req = 1'b1;
        step();
        check("t2_c1", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0111);
        check("t2_addr", sram_addr, 18'h3FFFF);
        check("t2_dout", sram_dout, 16'h5A5A);
        step();
        check("t2_c2", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0101);
        step();
        check("t2_rel", {sram_ce_n, sram_we_n, sram_dq_oe}, 3'b110);
        check("t2_ack", mem_ack, 1);
        check("t2_mem_rdata", mem_rdata, 0);
        check("t2_if_rdata", if_rdata, 16'hBEEF);
        mem_req = 1'b0; ref_mem[6'h3F] = 16'h5A5A;
        step();
        check("t2_ack_pulse", mem_ack, 0);

        // Contention from reset: MEM, IF, MEM, IF back to back.
        do_reset();
        if_addr = 18'h0003F; mem_addr = 18'h00010; mem_we = 1'b0;
        if_req = 1'b1; mem_req = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            step();
            check("t3_ce", sram_ce_n, (s % 3 == 0));
            check("t3_oe", sram_oe_n, (s % 3 == 0));
            check("t3_if_ack", if_ack, (s == 6 || s == 12));
            check("t3_mem_ack", mem_ack, (s == 3 || s == 9));
            if (s == 1) check("t3_first_addr", sram_addr, 18'h00010);
            if (s == 4) check("t3_second_addr", sram_addr, 18'h0003F);
            if (s == 3) check("t3_mem_rdata", mem_rdata, ref_mem[6'h10]);
            if (s == 6) check("t3_if_rdata", if_rdata, ref_mem[6'h3F]);
        end
        if_req = 1'b0; mem_req = 1'b0;
        step();
        check("t3_drain", {if_ack, mem_ack, sram_ce_n}, 3'b001);

        // MEM read withdrawn in the first access cycle.
        mem_we = 1'b0; mem_addr = 18'h00005; mem_req = 1'b1; acks = 0;
        step();
        mem_req = 1'b0;
        check("t4_running", sram_ce_n, 0);
        for (int s = 2; s <= 6; s++) begin
            step();
            acks += int'(mem_ack);
            if (s == 3) begin
                check("t4_ack", mem_ack, 1);
                check("t4_rdata", mem_rdata, ref_mem[6'h05]);
            end
        end
        check("t4_ack_count", acks, 1);

        // Reset asserted in the second cycle of a write.
        mem_we = 1'b1; mem_addr = 18'h00007; mem_wdata = 16'h1234; mem_req = 1'b1;
        step();
        step();
        check("t5_we_low", sram_we_n, 0);
        rst = 1'b1;
        #1;
        check("t5_async", {sram_ce_n, sram_we_n, sram_dq_oe}, 3'b110);
        mem_req = 1'b0; acks = 0;
        repeat (3) begin
            step();
            acks += int'(mem_ack);
        end
        check("t5_no_ack", acks, 0);
        rst = 1'b0;
        check("t5_rdata_clr", mem_rdata, 0);
        if_addr = 18'h00021; if_req = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            step();
            check("t5_after_ack", if_ack, (s == 3));
        end
        check("t5_after_rdata", if_rdata, ref_mem[6'h21]);
        if_req = 1'b0;
        step();

        // ACCESS_CYCLES = 5 instance.
        if_addr5 = 18'h00ABC; if_req5 = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            step();
            check("t6_ce", sram_ce_n5, (s >= 6));
            check("t6_oe", sram_oe_n5, (s >= 6));
            check("t6_ack", if_ack5, (s == 6));
            if (s == 1) check("t6_addr", sram_addr5, 18'h00ABC);
            if (s == 6) begin
                check("t6_rdata", if_rdata5, 16'hC0DE);
                if_req5 = 1'b0;
            end
        end

        // Randomized traffic against the word-level reference memory.
        if_wait = 0; mem_wait = 0;
        if_a = '0; mem_a = '0; mem_w = 1'b0; mem_d = '0;
        for (int n = 0; n < 3000; n++) begin
            step();
            check("r_if_stall", if_stall, if_req & ~if_ack);
            check("r_mem_stall", mem_stall, mem_req & ~mem_ack);
            check("r_oe_we_excl", (!sram_oe_n && !sram_we_n), 0);

            if (if_ack) begin
                check("r_if_req_held", if_req, 1);
                check("r_if_latency", (if_wait <= BOUND), 1);
                check("r_if_rdata", if_rdata, ref_mem[if_a[5:0]]);
                if_req = 1'b0;
            end else if (if_req) begin
                if_wait++;
                if (if_wait > BOUND) begin
                    check("r_if_timeout", if_wait, BOUND);
                    if_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_a = AW'($urandom); if_addr = if_a; if_req = 1'b1; if_wait = 0;
            end

            if (mem_ack) begin
                check("r_mem_req_held", mem_req, 1);
                check("r_mem_latency", (mem_wait <= BOUND), 1);
                if (mem_w) ref_mem[mem_a[5:0]] = mem_d;
                else       check("r_mem_rdata", mem_rdata, ref_mem[mem_a[5:0]]);
                mem_req = 1'b0;
            end else if (mem_req) begin
                mem_wait++;
                if (mem_wait > BOUND) begin
                    check("r_mem_timeout", mem_wait, BOUND);
                    mem_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                mem_a = AW'($urandom); mem_w = 1'($urandom_range(0, 1)); mem_d = DW'($urandom);
                mem_addr = mem_a; mem_we = mem_w; mem_wdata = mem_d;
                mem_req = 1'b1; mem_wait = 0;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single off-chip SRAM port between the instruction-fetch (IF) requester and the data-memory (MEM) requester of the 16-bit pipelined CPU.
- Sequences each access as a multi-cycle SRAM cycle with registered strobes.
- Returns read data with a one-cycle ack pulse.
- Drives per-requester stall lines that the pipeline-register control uses to hold stages.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, data width.
- ACCESS_CYCLES, 2, cycles the SRAM strobes are held per access; legal range 2..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request; level, held until if_ack.
- if_addr  in  ADDR_W  IF read address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_rdata valid in this cycle.
- if_rdata  out  DATA_W  IF read data; holds until the next IF completion.
- if_stall  out  1  if_req & ~if_ack.
- mem_req  in  1  MEM request; level, held until mem_ack.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_ack  out  1  one-cycle completion pulse.
- mem_rdata  out  DATA_W  MEM read data; valid at mem_ack after a read.
- mem_stall  out  1  mem_req & ~mem_ack.
- sram_addr  out  ADDR_W  registered SRAM address.
- sram_dout  out  DATA_W  registered write data.
- sram_dq_oe  out  1  1 = drive SRAM data bus (tristate lives outside this block).
- sram_din  in  DATA_W  SRAM data bus input.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - state=IDLE; owner=NONE; last_owner=IF.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
  - sram_addr=0, sram_dout=0, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0.
  - No ack is issued for an access aborted by reset.
- States:
  - IDLE: arbitrate.
  - ACCESS: strobes active; counter runs 1..ACCESS_CYCLES.
  - RELEASE: one cycle; strobes inactive; ack pulses.
- Arbitration in IDLE, from requests sampled at the clock edge:
  - If both are requesting: grant the requester that was NOT last_owner (alternating).
  - If only one is requesting: grant it.
- On grant:
  - Latch owner, address, write data and direction into the sram_* registers.
  - Go to ACCESS with cnt=1.
  - Update last_owner.
- ACCESS:
  - sram_ce_n=0 throughout.
  - Read: sram_oe_n=0 throughout; sram_we_n=1.
  - Write: sram_dq_oe=1 throughout; sram_we_n=0 only when cnt>=2, giving address setup in cycle 1; sram_oe_n=1.
  - sram_addr and sram_dout stay constant for the whole access.
  - When cnt==ACCESS_CYCLES: capture sram_din into the owner's rdata register (reads only) and go to RELEASE.
- RELEASE:
  - All strobes inactive; sram_dq_oe=0.
  - Owner's ack=1 for exactly this cycle.
  - The requester not just served may be granted here, going directly to ACCESS. The owner's still-high req is ignored in this cycle.
  - Otherwise go to IDLE.
- Latency:
  - Request sampled at edge E gives ACCESS in cycles E+1..E+ACCESS_CYCLES and ack in cycle E+ACCESS_CYCLES+1.
  - Peak throughput: one access per ACCESS_CYCLES+1 cycles.
- A request dropped mid-access is not cancelled; the access completes and ack still pulses.
- Input changes on address or data during ACCESS have no effect, because the values are latched.
- if_rdata and mem_rdata are unchanged by writes and by the other requester's accesses.
- cnt width: 4 bits. The counter never wraps because the state leaves ACCESS at ACCESS_CYCLES.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ACCESS, RELEASE}
  - owner enum {OWN_NONE, OWN_IF, OWN_MEM}
  - default ADDR_W and DATA_W constants, shared with the memory-stage blocks.
- One sub-module, sram_access_timer:
  - Counter with load/enable.
  - Outputs a last-cycle flag and a we-window flag (cnt>=2).
- The grant picker stays inline in the top-level block.

Test Plan:
- Single IF read:
  - Stimulus: ACCESS_CYCLES=2; if_req=1, if_addr=0x00123; sram_din=0xBEEF during ACCESS.
  - Required: sram_ce_n and sram_oe_n low for exactly 2 cycles; if_ack pulses 3 cycles after the sampling edge; if_rdata=0xBEEF; if_stall high until the ack cycle.
- MEM write:
  - Stimulus: mem_we=1, mem_addr=0x3FFFF, mem_wdata=0x5A5A.
  - Required: sram_dq_oe=1 for 2 cycles; sram_we_n low only in the 2nd cycle; sram_dout=0x5A5A; mem_ack one pulse; mem_rdata unchanged.
- Contention:
  - Stimulus: if_req and mem_req both held high for 12 cycles after reset (last_owner=IF).
  - Required: grant order MEM, IF, MEM; accesses back-to-back via RELEASE→ACCESS; acks every 3 cycles; no overlapping strobes.
- Request withdrawn:
  - Stimulus: mem_req dropped in the first ACCESS cycle.
  - Required: access still runs to completion and mem_ack pulses once.
- Reset mid-write:
  - Stimulus: rst asserted in the 2nd ACCESS cycle.
  - Required: sram_we_n=1 and sram_ce_n=1 immediately, without waiting for a clock edge; no ack; after rst deasserts, state is IDLE and a new request is served normally.
- Parameter sweep:
  - Stimulus: ACCESS_CYCLES=5, single read.
  - Required: strobes active for exactly 5 cycles; ack in cycle 6 after the sampling edge.
